// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit and the controller
// that drives it: op encodings on the mult_div_unit 'op' port, FSM state type,
// and the ALU op codes the controller decodes into mult/div/mfhi/mflo.
// No ports (package).
// -----------------------------------------------------------------------------
package mdu_pkg;

    // Encoding of the mult_div_unit 'op' input.
    localparam logic MDU_OP_MUL = 1'b0;
    localparam logic MDU_OP_DIV = 1'b1;

    // Unit state. MUL/DIV are the iterating states; DONE lasts one cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    // ALU op codes that involve this unit (controller decode).
    localparam logic [3:0] ALU_OP_MFLO = 4'd11;
    localparam logic [3:0] ALU_OP_MFHI = 4'd12;
    localparam logic [3:0] ALU_OP_DIV  = 4'd13;
    localparam logic [3:0] ALU_OP_MULT = 4'd14;

endpackage : mdu_pkg

// File: rtl/mdu_div_step.sv
// -----------------------------------------------------------------------------
// mdu_div_step
// One combinational step of an unsigned restoring divider.
//   rem_in       : partial remainder before this step
//   dividend_msb : next dividend bit shifted into the remainder
//   divisor      : divisor
//   rem_out      : partial remainder after the trial subtraction
//   quot_bit     : quotient bit produced by this step
// -----------------------------------------------------------------------------
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quot_bit
);

    // Remainder shifted left with the next dividend bit; one bit wider so
    // the trial subtraction sees the bit that would otherwise fall off.
    logic [WIDTH:0] shifted;

    assign shifted  = {rem_in, dividend_msb};

    // Non-negative trial difference <=> shifted >= divisor.
    assign quot_bit = (shifted >= {1'b0, divisor});

    // When the subtraction succeeds the true difference is below 2**WIDTH,
    // so the WIDTH-bit subtraction is exact. Otherwise restore.
    assign rem_out  = quot_bit ? (shifted[WIDTH-1:0] - divisor)
                               : shifted[WIDTH-1:0];

endmodule : mdu_div_step

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative unsigned multiply / divide producing the HI/LO pair read by the
// ALU's mfhi/mflo paths. Fixed WIDTH-cycle latency for both operations.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : launch request, honoured only in IDLE or DONE
//   op          : 0 = multiply, 1 = divide (sampled with start)
//   a, b        : multiplicand/dividend, multiplier/divisor (sampled with start)
//   busy        : operation iterating
//   done        : one-cycle pulse, hi/lo just written
//   div_by_zero : completed op was a divide by zero (held to next completion)
//   hi, lo      : mult {upper, lower} product; div {remainder, quotient}
// -----------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdu_state_t state, state_next;

    logic [CNT_W-1:0] count;

    // Working registers, shared between the two operations:
    //   MUL: opnd_q = multiplicand, acc_q = upper accumulator,
    //        shreg_q = multiplier shifting out / low product shifting in.
    //   DIV: opnd_q = divisor, acc_q = partial remainder,
    //        shreg_q = dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] shreg_q;

    logic             accept;
    logic             final_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0] mul_sh_next;
    logic [WIDTH-1:0] div_rem_next;
    logic [WIDTH-1:0] div_sh_next;
    logic             div_qbit;

    assign busy       = (state == ST_MUL) || (state == ST_DIV);
    assign done       = (state == ST_DONE);
    assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign final_iter = busy && (count == LAST_ITER);

    // ---- Multiply step: conditional add into upper half, then shift the
    //      {carry, accumulator, multiplier} chain right by one.
    assign mul_sum      = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_acc_next = mul_sum[WIDTH:1];
    assign mul_sh_next  = {mul_sum[0], shreg_q[WIDTH-1:1]};

    // ---- Divide step: dividend MSB feeds the remainder, quotient bit
    //      enters at the bottom of the shift register.
    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in       (acc_q),
        .dividend_msb (shreg_q[WIDTH-1]),
        .divisor      (opnd_q),
        .rem_out      (div_rem_next),
        .quot_bit     (div_qbit)
    );

    assign div_sh_next = {shreg_q[WIDTH-2:0], div_qbit};

    // ---- FSM state register
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order; blocking (=) would let
    // one flop see another's new value within the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- FSM next-state logic
    // NOTE: state_next gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (op == MDU_OP_DIV) ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (count == LAST_ITER) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = (op == MDU_OP_DIV) ? ST_DIV : ST_MUL;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---- Datapath and result registers
    // NOTE: every datapath register, including hi/lo, is cleared by reset so
    // an mfhi/mflo after reset reads a defined 0 and a cut-off operation
    // leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            shreg_q     <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count   <= '0;
            acc_q   <= '0;
            opnd_q  <= (op == MDU_OP_DIV) ? b : a;
            shreg_q <= (op == MDU_OP_DIV) ? a : b;
        end else if (state == ST_MUL) begin
            count   <= count + CNT_W'(1);
            acc_q   <= mul_acc_next;
            shreg_q <= mul_sh_next;
            if (final_iter) begin
                hi          <= mul_acc_next;
                lo          <= mul_sh_next;
                div_by_zero <= 1'b0;
            end
        end else if (state == ST_DIV) begin
            count   <= count + CNT_W'(1);
            acc_q   <= div_rem_next;
            shreg_q <= div_sh_next;
            if (final_iter) begin
                hi          <= div_rem_next;
                lo          <= div_sh_next;
                div_by_zero <= (opnd_q == '0);
            end
        end
    end

endmodule : mult_div_unit
